// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared widths, state encoding and direction codes for the collision scheduler
package collision_pkg;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int DIR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    localparam logic [DIR_W-1:0] DIR_NONE  = 3'd0;
    localparam logic [DIR_W-1:0] DIR_UP    = 3'd1;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd2;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd3;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd4;

    // Enemy index counts 0..n-1 but is sized to hold n as well
    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/collision_result_bank.sv
// rtl/collision_result_bank.sv - working and published per-frame collision results
module collision_result_bank
    import collision_pkg::*;
#(
    parameter int NUM_ENEMIES = 3,
    parameter int IDX_W       = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   store_i,
    input  logic                   publish_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic                   c_map_i,
    input  logic                   e_map_i,
    input  logic                   c_e_i,
    input  logic                   hit_i,
    output logic                   c_map_o,
    output logic [NUM_ENEMIES-1:0] e_map_o,
    output logic [NUM_ENEMIES-1:0] c_e_o,
    output logic [NUM_ENEMIES-1:0] hit_o
);

    logic                   work_cmap_q, work_cmap_d;
    logic [NUM_ENEMIES-1:0] work_emap_q, work_emap_d;
    logic [NUM_ENEMIES-1:0] work_ce_q,   work_ce_d;
    logic [NUM_ENEMIES-1:0] work_hit_q,  work_hit_d;

    logic                   out_cmap_q;
    logic [NUM_ENEMIES-1:0] out_emap_q;
    logic [NUM_ENEMIES-1:0] out_ce_q;
    logic [NUM_ENEMIES-1:0] out_hit_q;

    always_comb begin
        work_cmap_d = work_cmap_q;
        work_emap_d = work_emap_q;
        work_ce_d   = work_ce_q;
        work_hit_d  = work_hit_q;
        if (clear_i) begin
            work_cmap_d = 1'b0;
            work_emap_d = '0;
            work_ce_d   = '0;
            work_hit_d  = '0;
        end else if (store_i) begin
            work_cmap_d = work_cmap_q | c_map_i;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                if (idx_i == IDX_W'(i)) begin
                    work_emap_d[i] = e_map_i;
                    work_ce_d[i]   = c_e_i;
                    work_hit_d[i]  = hit_i;
                end
            end
        end
    end

    // Publishing takes the next working value so the last pass lands in the same frame
    always_ff @(posedge clock) begin
        if (reset) begin
            work_cmap_q <= 1'b0;
            work_emap_q <= '0;
            work_ce_q   <= '0;
            work_hit_q  <= '0;
            out_cmap_q  <= 1'b0;
            out_emap_q  <= '0;
            out_ce_q    <= '0;
            out_hit_q   <= '0;
        end else begin
            work_cmap_q <= work_cmap_d;
            work_emap_q <= work_emap_d;
            work_ce_q   <= work_ce_d;
            work_hit_q  <= work_hit_d;
            if (publish_i) begin
                out_cmap_q <= work_cmap_d;
                out_emap_q <= work_emap_d;
                out_ce_q   <= work_ce_d;
                out_hit_q  <= work_hit_d;
            end
        end
    end

    assign c_map_o = out_cmap_q;
    assign e_map_o = out_emap_q;
    assign c_e_o   = out_ce_q;
    assign hit_o   = out_hit_q;

endmodule

// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - time-multiplexes one collision_detector over NUM_ENEMIES enemies per frame
// Optional per-pass watchdog enabled by defining COLLISION_TIMEOUT_EN.
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int NUM_ENEMIES = 3
`ifdef COLLISION_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1023
`endif
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [X_W-1:0]               char_x,
    input  logic [Y_W-1:0]               char_y,
    input  logic [DIR_W-1:0]             direction_char,
    input  logic [DIR_W-1:0]             facing_char,
    input  logic                         attack,
    input  logic [X_W*NUM_ENEMIES-1:0]   enemy_x,
    input  logic [Y_W*NUM_ENEMIES-1:0]   enemy_y,
    input  logic [DIR_W*NUM_ENEMIES-1:0] enemy_dir,
    output logic                         det_init,
    output logic                         det_enable,
    output logic [X_W-1:0]               det_char_x,
    output logic [Y_W-1:0]               det_char_y,
    output logic [DIR_W-1:0]             det_dir_char,
    output logic [DIR_W-1:0]             det_facing_char,
    output logic                         det_attack,
    output logic [X_W-1:0]               det_enemy_x,
    output logic [Y_W-1:0]               det_enemy_y,
    output logic [DIR_W-1:0]             det_dir_enemy,
    input  logic                         det_c_map,
    input  logic                         det_e_map,
    input  logic                         det_c_e,
    input  logic                         det_e_hit,
    input  logic                         det_done,
    output logic                         c_map_collision,
    output logic [NUM_ENEMIES-1:0]       e_map_collision,
    output logic [NUM_ENEMIES-1:0]       c_e_collision,
    output logic [NUM_ENEMIES-1:0]       e_hit,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err
);

    localparam int               IDX_W    = idx_width(NUM_ENEMIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENEMIES - 1);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic accept;
    logic run_exit;
    logic tmo_hit;
    logic pass_tmo;
    logic bank_clear, bank_store, bank_publish;

    logic [X_W-1:0]               snap_cx_q;
    logic [Y_W-1:0]               snap_cy_q;
    logic [DIR_W-1:0]             snap_cdir_q;
    logic [DIR_W-1:0]             snap_cface_q;
    logic                         snap_attack_q;
    logic [X_W*NUM_ENEMIES-1:0]   snap_ex_q;
    logic [Y_W*NUM_ENEMIES-1:0]   snap_ey_q;
    logic [DIR_W*NUM_ENEMIES-1:0] snap_edir_q;

    assign accept   = (state_q == ST_IDLE) && start;
    assign run_exit = det_done || tmo_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN: begin
                if (run_exit) state_d = ST_STORE;
            end
            ST_STORE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        det_init     = 1'b0;
        det_enable   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        bank_clear   = 1'b0;
        bank_store   = 1'b0;
        bank_publish = 1'b0;
        case (state_q)
            ST_IDLE:  bank_clear = start;
            ST_LOAD: begin
                det_init = 1'b1;
                busy     = 1'b1;
            end
            ST_RUN: begin
                det_enable = 1'b1;
                busy       = 1'b1;
            end
            ST_STORE: begin
                busy         = 1'b1;
                bank_store   = 1'b1;
                bank_publish = (idx_q == LAST_IDX);
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            snap_cx_q     <= '0;
            snap_cy_q     <= '0;
            snap_cdir_q   <= '0;
            snap_cface_q  <= '0;
            snap_attack_q <= 1'b0;
            snap_ex_q     <= '0;
            snap_ey_q     <= '0;
            snap_edir_q   <= '0;
        end else if (accept) begin
            snap_cx_q     <= char_x;
            snap_cy_q     <= char_y;
            snap_cdir_q   <= direction_char;
            snap_cface_q  <= facing_char;
            snap_attack_q <= attack;
            snap_ex_q     <= enemy_x;
            snap_ey_q     <= enemy_y;
            snap_edir_q   <= enemy_dir;
        end
    end

    assign det_char_x      = snap_cx_q;
    assign det_char_y      = snap_cy_q;
    assign det_dir_char    = snap_cdir_q;
    assign det_facing_char = snap_cface_q;
    assign det_attack      = snap_attack_q;

    // Operands come only from the frame snapshot, so live enemy motion never reaches the detector
    always_comb begin
        det_enemy_x   = '0;
        det_enemy_y   = '0;
        det_dir_enemy = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                det_enemy_x   = snap_ex_q[i*X_W +: X_W];
                det_enemy_y   = snap_ey_q[i*Y_W +: Y_W];
                det_dir_enemy = snap_edir_q[i*DIR_W +: DIR_W];
            end
        end
    end

`ifdef COLLISION_TIMEOUT_EN
    logic [9:0] tmo_cnt_q;
    logic       pass_tmo_q;
    logic       work_err_q;
    logic       err_q;

    assign tmo_hit  = (state_q == ST_RUN) && !det_done
                      && (tmo_cnt_q == 10'(TIMEOUT_CYCLES - 1));
    assign pass_tmo = pass_tmo_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt_q  <= '0;
            pass_tmo_q <= 1'b0;
            work_err_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == ST_LOAD) begin
                tmo_cnt_q  <= '0;
                pass_tmo_q <= 1'b0;
            end else if (state_q == ST_RUN) begin
                tmo_cnt_q <= tmo_cnt_q + 10'd1;
                if (tmo_hit) pass_tmo_q <= 1'b1;
            end
            if (accept) begin
                work_err_q <= 1'b0;
            end else if (tmo_hit) begin
                work_err_q <= 1'b1;
            end
            if (bank_publish) err_q <= work_err_q;
        end
    end

    assign timeout_err = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign pass_tmo    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    collision_result_bank #(
        .NUM_ENEMIES (NUM_ENEMIES),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (bank_clear),
        .store_i   (bank_store),
        .publish_i (bank_publish),
        .idx_i     (idx_q),
        .c_map_i   (det_c_map & ~pass_tmo),
        .e_map_i   (det_e_map & ~pass_tmo),
        .c_e_i     (det_c_e & ~pass_tmo),
        .hit_i     (det_e_hit & ~pass_tmo),
        .c_map_o   (c_map_collision),
        .e_map_o   (e_map_collision),
        .c_e_o     (c_e_collision),
        .hit_o     (e_hit)
    );

endmodule
